// File: rtl/memory_access_stage_pkg.sv
// Shared opcodes, serial register map defaults and the state encoding of the memory stage.
package memory_access_stage_pkg;

  localparam logic [4:0] OP_LW    = 5'b10011;
  localparam logic [4:0] OP_LW_SP = 5'b10010;
  localparam logic [4:0] OP_SW    = 5'b11011;
  localparam logic [4:0] OP_SW_SP = 5'b11010;

  localparam logic [15:0] SERIAL_DATA_ADDR_DEF   = 16'hBF00;
  localparam logic [15:0] SERIAL_STATUS_ADDR_DEF = 16'hBF01;

  localparam int TMR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRAM_RD,
    ST_SRAM_WR_SETUP,
    ST_SRAM_WR_PULSE,
    ST_SRAM_WR_HOLD,
    ST_SERIAL_RD_WAIT,
    ST_SERIAL_WR_WAIT,
    ST_DONE
  } state_e;

  function automatic logic is_load(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_LW_SP);
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return (op == OP_SW) || (op == OP_SW_SP);
  endfunction

endpackage

// File: rtl/memory_access_stage_sram_strobe_timer.sv
// Loadable down-counter timing the SRAM strobe; done_o is high on the last strobe cycle.
module sram_strobe_timer import memory_access_stage_pkg::*; (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)           cnt_d = load_val_i;
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: runs loads/stores against SRAM or the serial port and emits one
// writeback record per accepted instruction.
module memory_access_stage import memory_access_stage_pkg::*; #(
  parameter int          WAIT_STATES        = 1,
  parameter logic [15:0] SERIAL_DATA_ADDR   = SERIAL_DATA_ADDR_DEF,
  parameter logic [15:0] SERIAL_STATUS_ADDR = SERIAL_STATUS_ADDR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic [15:0] instruction,
  input  logic [15:0] aluResult,
  input  logic [15:0] storeValue,
  input  logic [3:0]  destRegister,
  input  logic        destWriteEnable,
  output logic        busy,
  output logic [17:0] ramAddress,
  output logic [15:0] ramDataOut,
  input  logic [15:0] ramDataIn,
  output logic        ramDataDrive,
  output logic        ramEn_n,
  output logic        ramOe_n,
  output logic        ramWe_n,
  input  logic        serialRxReady,
  input  logic        serialTxReady,
  input  logic [7:0]  serialRxData,
  output logic        serialRead,
  output logic        serialWrite,
  output logic [7:0]  serialTxData,
  output logic        wbValid,
  output logic [15:0] wbValue,
  output logic [3:0]  wbRegister,
  output logic        wbEnable
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d, st_q, st_d, val_q, val_d;
  logic [3:0]  reg_q, reg_d;
  logic        en_q, en_d, nm_vld_q, nm_vld_d;
  logic        accept, ld, sto, tmr_load, tmr_done;
  logic        unused_instr;

  assign unused_instr = ^instruction[10:0];
  assign busy   = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign accept = inValid && !busy;
  assign ld     = is_load(instruction[15:11]);
  assign sto    = is_store(instruction[15:11]);

  sram_strobe_timer u_tmr (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (TMR_W'(WAIT_STATES - 1)),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    st_d     = st_q;
    val_d    = val_q;
    reg_d    = reg_q;
    en_d     = en_q;
    nm_vld_d = 1'b0;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d   = aluResult;
          st_d     = storeValue;
          val_d    = aluResult;
          reg_d    = destRegister;
          en_d     = ld ? 1'b1 : (sto ? 1'b0 : destWriteEnable);
          nm_vld_d = !(ld || sto);
          if (ld || sto) begin
            if (aluResult == SERIAL_DATA_ADDR)
              state_d = ld ? ST_SERIAL_RD_WAIT : ST_SERIAL_WR_WAIT;
            else if (aluResult == SERIAL_STATUS_ADDR) begin
              state_d = ST_DONE;
              val_d   = {14'b0, serialRxReady, serialTxReady};
            end else if (ld) begin
              state_d  = ST_SRAM_RD;
              tmr_load = 1'b1;
            end else
              state_d = ST_SRAM_WR_SETUP;
          end
        end
      end
      ST_SRAM_RD: if (tmr_done) begin
        val_d   = ramDataIn;
        state_d = ST_DONE;
      end
      ST_SRAM_WR_SETUP: begin
        tmr_load = 1'b1;
        state_d  = ST_SRAM_WR_PULSE;
      end
      ST_SRAM_WR_PULSE:  if (tmr_done) state_d = ST_SRAM_WR_HOLD;
      ST_SRAM_WR_HOLD:   state_d = ST_DONE;
      ST_SERIAL_RD_WAIT: if (serialRxReady) begin
        val_d   = {8'h00, serialRxData};
        state_d = ST_DONE;
      end
      ST_SERIAL_WR_WAIT: if (serialTxReady) state_d = ST_DONE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      st_q     <= '0;
      val_q    <= '0;
      reg_q    <= '0;
      en_q     <= 1'b0;
      nm_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      st_q     <= st_d;
      val_q    <= val_d;
      reg_q    <= reg_d;
      en_q     <= en_d;
      nm_vld_q <= nm_vld_d;
    end
  end

  // Data drive spans setup..hold and never overlaps the read enable.
  assign ramAddress   = {2'b00, addr_q};
  assign ramDataOut   = st_q;
  assign ramEn_n      = !(state_q inside {ST_SRAM_RD, ST_SRAM_WR_SETUP, ST_SRAM_WR_PULSE, ST_SRAM_WR_HOLD});
  assign ramOe_n      = (state_q != ST_SRAM_RD);
  assign ramWe_n      = (state_q != ST_SRAM_WR_PULSE);
  assign ramDataDrive = state_q inside {ST_SRAM_WR_SETUP, ST_SRAM_WR_PULSE, ST_SRAM_WR_HOLD};
  assign serialRead   = (state_q == ST_SERIAL_RD_WAIT) && serialRxReady;
  assign serialWrite  = (state_q == ST_SERIAL_WR_WAIT) && serialTxReady;
  assign serialTxData = st_q[7:0];
  assign wbValid      = (state_q == ST_DONE) || nm_vld_q;
  assign wbValue      = val_q;
  assign wbRegister   = reg_q;
  assign wbEnable     = en_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
Pipeline stage after the ALU. It consumes the ALU result as either an address or a pass-through writeback value. It executes LW, LW_SP, SW and SW_SP against the external SRAM or the memory-mapped serial port, stalls the front of the pipe while a transaction is in flight, and presents one writeback record per accepted instruction.

Parameters:
WAIT_STATES, 1, SRAM strobe width in cycles (1..7).
SERIAL_DATA_ADDR, 16'hBF00, serial data register address.
SERIAL_STATUS_ADDR, 16'hBF01, serial status register address (read-only).

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
inValid  in  1  instruction record presented this cycle
instruction  in  16  instruction word; opcode in [15:11]
aluResult  in  16  ALU targetValue: address for memory ops, result otherwise
storeValue  in  16  data to store for SW and SW_SP
destRegister  in  4  writeback register index
destWriteEnable  in  1  instruction writes a register
busy  out  1  stage cannot accept; upstream holds its record
ramAddress  out  18  SRAM address, {2'b00, addr}
ramDataOut  out  16  SRAM write data
ramDataIn  in  16  SRAM read data
ramDataDrive  out  1  tri-state enable for ramDataOut
ramEn_n  out  1  SRAM chip enable, active-low
ramOe_n  out  1  SRAM output enable, active-low
ramWe_n  out  1  SRAM write enable, active-low
serialRxReady  in  1  receive byte available
serialTxReady  in  1  transmitter idle
serialRxData  in  8  received byte
serialRead  out  1  one-cycle pop strobe
serialWrite  out  1  one-cycle send strobe
serialTxData  out  8  byte to send
wbValid  out  1  one-cycle pulse: writeback record valid
wbValue  out  16  writeback value
wbRegister  out  4  writeback index
wbEnable  out  1  register write requested

Behaviour:
- Reset values: busy 0, ramEn_n 1, ramOe_n 1, ramWe_n 1, ramDataDrive 0, serialRead 0, serialWrite 0, wbValid 0, all data and address outputs 0, state IDLE.
- Accept condition: inValid && !busy at a rising edge. On accept, latch instruction, aluResult, storeValue, destRegister and destWriteEnable.
- Load ops (LW 10011, LW_SP 10010) force wbEnable=1. Store ops (SW 11011, SW_SP 11010) force wbEnable=0.
- Non-memory op: no state change. wbValid pulses in the next cycle with wbValue=aluResult, wbEnable=destWriteEnable, busy stays 0. Throughput is 1 per cycle.
- busy is combinational: high in every state other than IDLE and DONE.
- State flow: IDLE -> SRAM_RD | SRAM_WR_SETUP | SERIAL_RD_WAIT | SERIAL_WR_WAIT | DONE.
- SRAM_RD: ramEn_n=0 and ramOe_n=0 for WAIT_STATES cycles. ramDataIn is captured on the last cycle, then -> DONE. Load latency is WAIT_STATES+1 cycles from accept to wbValid.
- SRAM_WR_SETUP: 1 cycle with address and data driven, ramDataDrive=1, ramEn_n=0, then -> SRAM_WR_PULSE.
- SRAM_WR_PULSE: ramWe_n=0 for WAIT_STATES cycles, then -> SRAM_WR_HOLD.
- SRAM_WR_HOLD: ramWe_n=1, address and data held 1 cycle, then -> DONE.
- ramDataDrive is never high while ramOe_n is 0.
- SERIAL_RD_WAIT (load from SERIAL_DATA_ADDR): wait while serialRxReady=0, with no timeout. When it is 1, pulse serialRead for 1 cycle, wbValue={8'h00, serialRxData}, then -> DONE.
- SERIAL_WR_WAIT (store to SERIAL_DATA_ADDR): wait for serialTxReady=1, pulse serialWrite for 1 cycle with serialTxData=storeValue[7:0], then -> DONE.
- Load from SERIAL_STATUS_ADDR: goes to DONE directly with wbValue={14'b0, serialRxReady, serialTxReady}, sampled at accept.
- Store to SERIAL_STATUS_ADDR: goes to DONE with no side effect.
- DONE: wbValid=1 for 1 cycle, then -> IDLE. A new accept is allowed in DONE, so back-to-back transactions are supported.
- Address decode uses the full 16 bits. Addresses BF02..BFFF go to SRAM.
- Reset mid-transaction: at the next edge all strobes deassert, the latched record is discarded and no wbValid is produced.

Decomposition:
- Shared package: opcode constants (LW, LW_SP, SW, SW_SP), serial addresses, state encoding.
- One natural sub-module: sram_strobe_timer. It is a loadable down-counter with a done flag, used by SRAM_RD and SRAM_WR_PULSE.

Test Plan:
- ADDU record, aluResult=16'h1234, dest=3 -> next cycle wbValid=1, wbValue=1234, wbRegister=3, busy never asserted.
- SW to 16'h4000, storeValue=16'hBEEF, WAIT_STATES=2 -> ramAddress=18'h04000, 1 setup cycle, ramWe_n low for exactly 2 cycles, 1 hold cycle, then wbValid with wbEnable=0.
- LW from 16'h4000 with ramDataIn=16'hBEEF -> wbValue=BEEF, wbEnable=1, wbValid 3 cycles after accept (WAIT_STATES=2).
- SW to BF00 with serialTxReady low for 5 cycles, storeValue=16'h1241 -> busy held, single serialWrite pulse with serialTxData=8'h41 after ready rises.
- LW from BF01 with rx=1, tx=0 -> wbValue=16'h0002. LW from BF00 with rxData=8'h5A -> wbValue=16'h005A, one serialRead pulse.
- Reset asserted during SRAM_WR_PULSE -> ramWe_n=1 and busy=0 the next cycle, no wbValid pulse.
